// File: rtl/gf_inv_pkg.sv
// Shared sizes, FSM state encoding and element storage type for the GF(2^m) inverter.
package gf_inv_pkg;
    localparam int N_ELEM = 4;
    localparam int DATA_W = 5;
    localparam int DEG_W  = 3;
    localparam int POLY_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } state_e;

    typedef logic [N_ELEM-1:0][DATA_W-1:0] elem_arr_t;

    function automatic logic deg_ok(input logic [DEG_W-1:0] d);
        return (d >= DEG_W'(2)) && (d <= DEG_W'(5));
    endfunction

    // Keeps the low m bits of an element; an unsupported degree zeroes everything.
    function automatic logic [DATA_W-1:0] elem_mask(input logic [DEG_W-1:0] d);
        logic [DATA_W:0] full;
        full = ((DATA_W+1)'(1) << d) - (DATA_W+1)'(1);
        return deg_ok(d) ? full[DATA_W-1:0] : '0;
    endfunction
endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^m) multiplier: carry-less product reduced by a runtime polynomial.
module gf_mul
    import gf_inv_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DEG_W-1:0]  deg_i,
    input  logic [POLY_W-1:0] poly_i,
    output logic [DATA_W-1:0] p_o
);
    localparam int PROD_W = 2*DATA_W - 1;

    logic [PROD_W-1:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (b_i[i]) prod = prod ^ (PROD_W'(a_i) << i);
        end
        // Clear bits from the top down; poly carries bit m so each xor cancels bit i.
        for (int i = PROD_W-1; i >= 2; i--) begin
            if (i >= int'(deg_i) && prod[i]) prod = prod ^ (PROD_W'(poly_i) << (i - int'(deg_i)));
        end
        p_o = prod[DATA_W-1:0] & elem_mask(deg_i);
    end
endmodule

// File: rtl/gf_inv_array.sv
// Batch GF(2^m) inverter: loads four elements, computes a^(2^m-2) serially, streams results out.
module gf_inv_array
    import gf_inv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DEG_W-1:0]  deg,
    input  logic [POLY_W-1:0] poly,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output state_e            dbg_state_o
);
    // Streams: in_valid frames exactly 4 consecutive input beats (deg/poly on beat 0 only);
    // out_valid frames exactly 4 consecutive result beats, out_data is 0 between frames.
    // There is no backpressure; in_valid outside IDLE/LOAD is ignored.
    state_e            state_q;
    logic [DEG_W-1:0]  deg_q;
    logic [POLY_W-1:0] poly_q;
    elem_arr_t         elem_q;
    elem_arr_t         res_q;
    logic [DATA_W-1:0] sq_q, acc_q;
    logic [1:0]        idx_q;
    logic [1:0]        step_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;

    logic [DATA_W-1:0] sq_cur, acc_cur, sq_d, acc_d;
    logic [DEG_W-1:0]  m_eff;
    logic              last_step;

    // Step 0 of each element seeds sq=a, acc=1 without spending a cycle on it.
    always_comb begin
        sq_cur    = (step_q == 2'd0) ? elem_q[idx_q] : sq_q;
        acc_cur   = (step_q == 2'd0) ? DATA_W'(1) : acc_q;
        m_eff     = deg_ok(deg_q) ? deg_q : DEG_W'(2);
        last_step = ({1'b0, step_q} == (m_eff - DEG_W'(2)));
    end

    gf_mul u_sq (
        .a_i   (sq_cur),
        .b_i   (sq_cur),
        .deg_i (deg_q),
        .poly_i(poly_q),
        .p_o   (sq_d)
    );

    gf_mul u_acc (
        .a_i   (acc_cur),
        .b_i   (sq_d),
        .deg_i (deg_q),
        .poly_i(poly_q),
        .p_o   (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            deg_q       <= '0;
            poly_q      <= '0;
            elem_q      <= '0;
            res_q       <= '0;
            sq_q        <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            step_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        deg_q     <= deg;
                        poly_q    <= poly;
                        elem_q[0] <= in_data & elem_mask(deg);
                        idx_q     <= 2'd1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    elem_q[idx_q] <= in_data & elem_mask(deg_q);
                    idx_q         <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        step_q  <= 2'd0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    sq_q  <= sq_d;
                    acc_q <= acc_d;
                    if (last_step) begin
                        res_q[idx_q] <= acc_d;
                        step_q       <= 2'd0;
                        idx_q        <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            // Element 0 finished long ago, so its result can go out now.
                            out_valid_q <= 1'b1;
                            out_data_q  <= res_q[0];
                            state_q     <= OUT;
                        end
                    end else begin
                        step_q <= step_q + 2'd1;
                    end
                end
                OUT: begin
                    if (idx_q == 2'd3) begin
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        idx_q       <= 2'd0;
                        state_q     <= IDLE;
                    end else begin
                        out_data_q <= res_q[idx_q + 2'd1];
                        idx_q      <= idx_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_gf_inv_array.sv
// Directed bench for gf_inv_array: jobs push expected results and start cycles, a monitor checks them.
module tb_gf_inv_array;
    import gf_inv_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DEG_W-1:0]  deg;
    logic [POLY_W-1:0] poly;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    state_e            dbg_state;

    logic [DATA_W-1:0] exp_q[$];
    int                exp_t_q[$];
    int                cyc = 0;
    int                pass_cnt = 0;
    int                chk_cnt = 0;
    logic              prev_ov = 1'b0;

    gf_inv_array dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .deg        (deg),
        .poly       (poly),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .dbg_state_o(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic elem_arr_t pack4(input int a, input int b, input int c, input int d);
        elem_arr_t v;
        v[0] = DATA_W'(a); v[1] = DATA_W'(b); v[2] = DATA_W'(c); v[3] = DATA_W'(d);
        return v;
    endfunction

    // Driver: called #1 after a rising edge. deg/poly carry junk on beats 1..3.
    task automatic send_job(input logic [DEG_W-1:0] m, input logic [POLY_W-1:0] p,
                            input elem_arr_t data, input elem_arr_t exp, input bit expect_out);
        int l_cyc;
        int m_lat;
        l_cyc = 0;
        for (int k = 0; k < N_ELEM; k++) begin
            in_valid = 1'b1;
            in_data  = data[k];
            deg      = (k == 0) ? m : 3'd7;
            poly     = (k == 0) ? p : 6'h3f;
            if (k == N_ELEM-1) l_cyc = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
        deg      = '0;
        poly     = '0;
        if (expect_out) begin
            m_lat = (m >= 3'd2 && m <= 3'd5) ? int'(m) : 2;
            exp_t_q.push_back(l_cyc + 4*(m_lat-1) + 1);
            for (int k = 0; k < N_ELEM; k++) exp_q.push_back(exp[k]);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_t_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain_timeout"}, (n < 300) ? 1 : 0, 1);
    endtask

    // Returns #1 into the first cycle after out_valid falls.
    task automatic wait_out_end();
        int n;
        n = 0;
        while (!out_valid && n < 300) begin @(posedge clk); #1; n++; end
        while (out_valid && n < 300) begin @(posedge clk); #1; n++; end
        check("wait_out_end_timeout", (n < 300) ? 1 : 0, 1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_ov) begin
                    if (exp_t_q.size() == 0) check("unexpected_out_start", cyc, -1);
                    else check("out_start_cycle", cyc, exp_t_q.pop_front());
                end
                if (exp_q.size() == 0) check("unexpected_out_beat", int'(out_data), -1);
                else check("out_data", int'(out_data), int'(exp_q.pop_front()));
            end else begin
                check("out_data_idle_zero", int'(out_data), 0);
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; deg = '0; poly = '0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_state", int'(dbg_state), int'(IDLE));
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_out_valid", int'(out_valid), 0);

        send_job(3'd3, 6'd11, pack4(0, 2, 3, 4), pack4(0, 5, 6, 7), 1'b1);
        wait_drain("m3");

        // Junk in_valid during CALC must not disturb the job.
        send_job(3'd4, 6'd19, pack4(1, 2, 3, 8), pack4(1, 9, 14, 15), 1'b1);
        in_valid = 1'b1; in_data = 5'd31; deg = 3'd5; poly = 6'd37;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0; in_data = '0; deg = '0; poly = '0;
        wait_drain("m4");

        send_job(3'd5, 6'd37, pack4(2, 1, 0, 2), pack4(18, 1, 0, 18), 1'b1);
        wait_drain("m5");

        send_job(3'd2, 6'd7, pack4(18, 3, 1, 0), pack4(3, 2, 1, 0), 1'b1);
        wait_drain("m2_mask");

        send_job(3'd7, 6'd11, pack4(1, 2, 3, 4), pack4(0, 0, 0, 0), 1'b1);
        wait_drain("m7_invalid");
        send_job(3'd1, 6'd3, pack4(1, 1, 1, 1), pack4(0, 0, 0, 0), 1'b1);
        wait_drain("m1_invalid");

        // Abort an m=5 job mid-CALC; the monitor flags any out_valid it produces.
        send_job(3'd5, 6'd37, pack4(2, 1, 0, 2), pack4(0, 0, 0, 0), 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        check("abort_in_calc", int'(dbg_state), int'(CALC));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state", int'(dbg_state), int'(IDLE));
        check("abort_out_valid", int'(out_valid), 0);
        repeat (30) begin @(posedge clk); #1; end
        send_job(3'd3, 6'd11, pack4(0, 2, 3, 4), pack4(0, 5, 6, 7), 1'b1);
        wait_drain("post_abort_m3");

        // Back-to-back: second job starts the cycle after out_valid falls.
        send_job(3'd3, 6'd11, pack4(4, 3, 2, 1), pack4(7, 6, 5, 1), 1'b1);
        wait_out_end();
        send_job(3'd4, 6'd19, pack4(8, 3, 2, 1), pack4(15, 14, 9, 1), 1'b1);
        wait_drain("b2b");

        repeat (3) @(posedge clk);
        #1;
        check("final_exp_q_empty", exp_q.size(), 0);
        check("final_exp_t_q_empty", exp_t_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/gf_inv_array.md
GF_INV_ARRAY -- requirements
Module: gf_inv_array

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: high for exactly 4 consecutive cycles per job.
REQ-004 SHALL have port deg, input, 3 bits: field degree m, valid only on the first in_valid cycle.
REQ-005 SHALL have port poly, input, 6 bits: field polynomial including bit m, valid only on the first in_valid cycle.
REQ-006 SHALL have port in_data, input, 5 bits: one GF(2^m) element per in_valid cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: high for exactly 4 consecutive cycles per job.
REQ-008 SHALL have port out_data, output, 5 bits: inverse of the element from the matching input cycle, in input order.

Function
REQ-009 SHALL implement states IDLE, LOAD, CALC, OUT. Transitions: IDLE->LOAD on in_valid; LOAD->CALC after the 4th sample; CALC->OUT after the final step; OUT->IDLE after the 4th output.
REQ-010 SHALL capture deg and poly on the first in_valid cycle only, and ignore them on all other cycles.
REQ-011 SHALL mask in_data bits at positions >= m on capture.
REQ-012 SHALL support m in 2..5; for m in {0,1,6,7}, timing SHALL be as for m=2 and all out_data SHALL be 0.
REQ-013 SHALL compute inv(a) = a^(2^m-2) per element: acc=1, sq=a; repeat m-1 times {sq=sq*sq; acc=acc*sq}; result=acc.
REQ-014 SHALL perform one iteration per cycle and process elements serially, so CALC lasts exactly 4*(m-1) cycles.
REQ-015 SHALL produce inv(0)=0 through the algorithm itself, with no special-case path.
REQ-016 SHALL reduce every product modulo poly to m bits, with upper out_data bits equal to 0.
REQ-017 SHALL hold the timing: if the 4th in_valid cycle is cycle L, out_valid is high in cycles L+4(m-1)+1 through L+4(m-1)+4 and low otherwise.
REQ-018 SHALL drive out_data to 0 whenever out_valid is low.
REQ-019 SHALL ignore in_valid asserted during CALC or OUT, with no state corruption.
REQ-020 SHALL accept a new job in the cycle immediately after the last out_valid cycle.

Reset
REQ-021 SHALL, while rst is high at a clock edge, set state=IDLE, out_valid=0, out_data=0, and clear all captured data, counters and accumulators.
REQ-022 SHALL treat reset asserted mid-operation (LOAD/CALC/OUT) as an abort: the partial job is discarded and no further out_valid occurs for it.
REQ-023 SHALL keep outputs at 0 on the first edge after rst deasserts until a new job completes.

Structure
REQ-024 SHALL place in a shared package gf_inv_pkg: N_ELEM=4, DATA_W=5, DEG_W=3, POLY_W=6, the state enum typedef, and the element-array typedef.
REQ-025 SHALL use sub-module gf_mul: combinational 5x5-bit carry-less multiply reduced modulo runtime poly/deg. Two instances SHALL be used, one for squaring and one for the accumulate step.
REQ-026 SHALL use a step counter (0..m-2) and an element index (0..3) for CALC, and an output index (0..3) for OUT.

Verification
REQ-027 SHALL cover: m=3, poly=11, data 0,2,3,4 -> out 0,5,6,7, with out_valid first high at L+9.
REQ-028 SHALL cover: m=4, poly=19, data 1,2,3,8 -> out 1,9,14,15, with out_valid first high at L+13.
REQ-029 SHALL cover: m=5, poly=37, data 2,1,0,2 -> out 18,1,0,18, with out_valid first high at L+17.
REQ-030 SHALL cover: m=2, poly=7, data 2,3,1,0 (data 2 with bit 4 set, i.e. 18, to check masking) -> out 3,2,1,0.
REQ-031 SHALL cover: rst pulsed for 1 cycle during CALC of an m=5 job -> out_valid never rises for that job; the next m=3 job is correct.
REQ-032 SHALL cover: back-to-back jobs with in_valid rising the cycle after out_valid falls -> both correct, and no out_valid gap shorter than the stated latency.
